// File: rtl/fv_core_if_dup_queue.sv
// fv_core_if_dup_queue: instruction-fetch duplicate queue.
// Each original instruction is enqueued and replayed once as a duplicate.
// The FSM tracks ORIG / DUP / PASSTHRU. In PASSTHRU the queue is frozen
// until the downstream flush resolves.
// Optional feature: define FV_DUP_QUEUE_AUTO_EXIT_EN to leave PASSTHRU
// automatically after PASSTHRU_TIMEOUT enabled cycles.
// Handshake: a push or pop takes effect only on a cycle where it is accepted.
// Acceptance is decided from registered state and the current inputs, and the
// result becomes visible after the next posedge.
`ifndef FV_INSTR_WIDTH
`define FV_INSTR_WIDTH 32
`endif
`ifndef FV_INSTR_NOP
`define FV_INSTR_NOP 32'h0000_0013
`endif

module fv_core_if_dup_queue #(
   parameter int DEPTH            = 4,
   parameter int PASSTHRU_TIMEOUT = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       enable,
   input  logic                       queue_push,
   input  logic                       queue_pop,
   input  logic [`FV_INSTR_WIDTH-1:0] push_instr,
   input  logic                       push_predict_br_taken,
   input  logic                       goto_passthru_mode,
   input  logic                       passthru_exit,
   input  logic                       flush,
   output logic [`FV_INSTR_WIDTH-1:0] head_instr,
   output logic                       head_predict_br_taken,
   output logic                       is_empty,
   output logic                       is_full,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       in_dup_mode,
   output logic                       in_passthru_mode,
   output logic                       overflow_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int IW = `FV_INSTR_WIDTH;

   localparam logic [1:0] ST_ORIG = 2'd0;
   localparam logic [1:0] ST_DUP  = 2'd1;
   localparam logic [1:0] ST_PASS = 2'd2;

   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [1:0]    state_q, state_d;
   logic          ovf_q, ovf_d;
   logic [IW-1:0] instr_mem_q [DEPTH];
   logic [IW-1:0] instr_mem_d [DEPTH];
   logic          pred_mem_q  [DEPTH];
   logic          pred_mem_d  [DEPTH];

   logic is_pass, full_w, empty_w;
   logic pop_acc, push_acc, push_ovf, exit_now;

`ifdef FV_DUP_QUEUE_AUTO_EXIT_EN
   localparam int TW = $clog2(PASSTHRU_TIMEOUT) + 1;
   logic [TW-1:0] tmr_q, tmr_d;
   assign exit_now = passthru_exit || (tmr_q == TW'(PASSTHRU_TIMEOUT - 1));
`else
   logic unused_timeout;
   assign unused_timeout = (PASSTHRU_TIMEOUT > 0);
   assign exit_now       = passthru_exit;
`endif

   assign is_pass  = (state_q == ST_PASS);
   assign full_w   = (count_q == CW'(DEPTH));
   assign empty_w  = (count_q == '0);
   assign pop_acc  = enable && queue_pop && !empty_w && !is_pass;
   assign push_acc = enable && queue_push && !is_pass && (!full_w || pop_acc);
   assign push_ovf = enable && queue_push && !is_pass && full_w && !pop_acc;

   assign head_instr            = instr_mem_q[rd_ptr_q];
   assign head_predict_br_taken = pred_mem_q[rd_ptr_q];
   assign is_empty              = empty_w;
   assign is_full               = full_w;
   assign count                 = count_q;
   assign in_dup_mode           = (state_q == ST_DUP);
   assign in_passthru_mode      = is_pass;
   assign overflow_err          = ovf_q;

   // Next-state: FIFO update, then FSM by priority flush > goto > exit > pop.
   always_comb begin
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      state_d     = state_q;
      ovf_d       = ovf_q;
      instr_mem_d = instr_mem_q;
      pred_mem_d  = pred_mem_q;
`ifdef FV_DUP_QUEUE_AUTO_EXIT_EN
      tmr_d       = tmr_q;
`endif
      if (push_acc) begin
         instr_mem_d[wr_ptr_q] = push_instr;
         pred_mem_d[wr_ptr_q]  = push_predict_br_taken;
         wr_ptr_d              = wr_ptr_q + PW'(1);
      end
      if (pop_acc) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push_acc, pop_acc})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (push_ovf) begin
         ovf_d = 1'b1;
      end
      if (enable) begin
         if (goto_passthru_mode) begin
            state_d = ST_PASS;
`ifdef FV_DUP_QUEUE_AUTO_EXIT_EN
            tmr_d   = '0;
`endif
         end else if (is_pass && exit_now) begin
            state_d  = ST_ORIG;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
         end else if (is_pass) begin
`ifdef FV_DUP_QUEUE_AUTO_EXIT_EN
            tmr_d = tmr_q + TW'(1);
`endif
         end else if (pop_acc) begin
            // Original leaves the queue; duplicate mode only if older entries remain.
            if (state_q == ST_ORIG && count_q > CW'(1)) begin
               state_d = ST_DUP;
            end else if (state_q == ST_DUP && count_d == '0) begin
               state_d = ST_ORIG;
            end
         end
      end
      if (flush) begin
         rd_ptr_d    = '0;
         wr_ptr_d    = '0;
         count_d     = '0;
         state_d     = ST_ORIG;
         ovf_d       = ovf_q;
         instr_mem_d = instr_mem_q;
         pred_mem_d  = pred_mem_q;
`ifdef FV_DUP_QUEUE_AUTO_EXIT_EN
         tmr_d       = '0;
`endif
      end
   end

   // State registers with synchronous active-low reset; storage reset to NOP.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         state_q  <= ST_ORIG;
         ovf_q    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            instr_mem_q[i] <= `FV_INSTR_NOP;
            pred_mem_q[i]  <= 1'b0;
         end
`ifdef FV_DUP_QUEUE_AUTO_EXIT_EN
         tmr_q <= '0;
`endif
      end else begin
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         state_q     <= state_d;
         ovf_q       <= ovf_d;
         instr_mem_q <= instr_mem_d;
         pred_mem_q  <= pred_mem_d;
`ifdef FV_DUP_QUEUE_AUTO_EXIT_EN
         tmr_q <= tmr_d;
`endif
      end
   end

endmodule

// File: tb/tb_fv_core_if_dup_queue.sv
// Testbench for fv_core_if_dup_queue: directed scenarios plus random traffic,
// all checked against a queue-based reference model.
`ifndef FV_INSTR_WIDTH
`define FV_INSTR_WIDTH 32
`endif
`ifndef FV_INSTR_NOP
`define FV_INSTR_NOP 32'h0000_0013
`endif

module tb_fv_core_if_dup_queue;

   localparam int DEPTH = 4;
   localparam int TMO   = 8;
   localparam int W     = `FV_INSTR_WIDTH;
   localparam int M_ORIG = 0;
   localparam int M_DUP  = 1;
   localparam int M_PASS = 2;

   logic         clk = 1'b0;
   logic         rst_n, enable, queue_push, queue_pop;
   logic [W-1:0] push_instr;
   logic         push_predict_br_taken, goto_passthru_mode, passthru_exit, flush;
   logic [W-1:0] head_instr;
   logic         head_predict_br_taken, is_empty, is_full;
   logic [$clog2(DEPTH):0] count;
   logic         in_dup_mode, in_passthru_mode, overflow_err;

   // reference model state
   logic [W:0]   exp_q[$];
   int           m_mode;
   int           m_tmr;
   logic         m_ovf;

   int           n_checks = 0;
   int           n_errors = 0;

   fv_core_if_dup_queue #(.DEPTH(DEPTH), .PASSTHRU_TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .queue_push(queue_push),
      .queue_pop(queue_pop), .push_instr(push_instr),
      .push_predict_br_taken(push_predict_br_taken),
      .goto_passthru_mode(goto_passthru_mode), .passthru_exit(passthru_exit),
      .flush(flush), .head_instr(head_instr),
      .head_predict_br_taken(head_predict_br_taken), .is_empty(is_empty),
      .is_full(is_full), .count(count), .in_dup_mode(in_dup_mode),
      .in_passthru_mode(in_passthru_mode), .overflow_err(overflow_err)
   );

   // clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // advance the model by one clock edge using the currently driven inputs
   task automatic model_step();
      int  old_n;
      bit  pass, pop_ok, push_ok, auto_exit;
      if (!rst_n) begin
         exp_q.delete(); m_mode = M_ORIG; m_tmr = 0; m_ovf = 1'b0;
      end else if (flush) begin
         exp_q.delete(); m_mode = M_ORIG; m_tmr = 0;
      end else if (enable) begin
         pass    = (m_mode == M_PASS);
         old_n   = exp_q.size();
         pop_ok  = queue_pop && old_n > 0 && !pass;
         push_ok = queue_push && !pass && (old_n < DEPTH || pop_ok);
         if (queue_push && !pass && !push_ok) m_ovf = 1'b1;
         if (pop_ok) void'(exp_q.pop_front());
         if (push_ok) exp_q.push_back({push_predict_br_taken, push_instr});
`ifdef FV_DUP_QUEUE_AUTO_EXIT_EN
         auto_exit = (m_tmr == TMO - 1);
`else
         auto_exit = 1'b0;
`endif
         if (goto_passthru_mode) begin
            m_mode = M_PASS; m_tmr = 0;
         end else if (pass && (passthru_exit || auto_exit)) begin
            m_mode = M_ORIG; exp_q.delete();
         end else if (pass) begin
            m_tmr++;
         end else if (pop_ok) begin
            if (m_mode == M_ORIG && old_n > 1) m_mode = M_DUP;
            else if (m_mode == M_DUP && exp_q.size() == 0) m_mode = M_ORIG;
         end
      end
   endtask

   task automatic check_all();
      chk("count", 64'(count), 64'(exp_q.size()));
      chk("is_empty", 64'(is_empty), 64'(exp_q.size() == 0));
      chk("is_full", 64'(is_full), 64'(exp_q.size() == DEPTH));
      chk("in_dup_mode", 64'(in_dup_mode), 64'(m_mode == M_DUP));
      chk("in_passthru_mode", 64'(in_passthru_mode), 64'(m_mode == M_PASS));
      chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
      if (exp_q.size() > 0) begin
         chk("head_instr", 64'(head_instr), 64'(exp_q[0][W-1:0]));
         chk("head_pred", 64'(head_predict_br_taken), 64'(exp_q[0][W]));
      end
   endtask

   // drive one cycle, update the model, then check after the edge
   task automatic step(input logic rst, input logic en, input logic push, input logic pop,
                       input logic [W-1:0] instr, input logic pred, input logic go,
                       input logic ex, input logic fl);
      @(negedge clk);
      rst_n = ~rst; enable = en; queue_push = push; queue_pop = pop;
      push_instr = instr; push_predict_br_taken = pred;
      goto_passthru_mode = go; passthru_exit = ex; flush = fl;
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      step(1, 0, 0, 0, '0, 0, 0, 0, 0);
   endtask

   task automatic push1(input logic [W-1:0] v, input logic p);
      step(0, 1, 1, 0, v, p, 0, 0, 0);
   endtask

   task automatic pop1();
      step(0, 1, 0, 1, '0, 0, 0, 0, 0);
   endtask

   initial begin
      int pass_cycles;
      rst_n = 1'b0; enable = 1'b0; queue_push = 1'b0; queue_pop = 1'b0;
      push_instr = '0; push_predict_br_taken = 1'b0;
      goto_passthru_mode = 1'b0; passthru_exit = 1'b0; flush = 1'b0;
      m_mode = M_ORIG; m_tmr = 0; m_ovf = 1'b0;

      // reset state
      do_reset();
      do_reset();
      chk("rst_is_empty", 64'(is_empty), 64'd1);
      chk("rst_is_full", 64'(is_full), 64'd0);
      chk("rst_dup", 64'(in_dup_mode), 64'd0);
      chk("rst_pass", 64'(in_passthru_mode), 64'd0);
      chk("rst_head_nop", 64'(head_instr), 64'(`FV_INSTR_NOP));
      chk("rst_head_pred", 64'(head_predict_br_taken), 64'd0);

      // fill to full, then overflow
      push1(32'hA, 1); push1(32'hB, 0); push1(32'hC, 1); push1(32'hD, 0);
      chk("full_flag", 64'(is_full), 64'd1);
      chk("full_count", 64'(count), 64'd4);
      push1(32'hE, 1);
      chk("ovf_set", 64'(overflow_err), 64'd1);
      chk("ovf_head", 64'(head_instr), 64'hA);
      chk("ovf_count", 64'(count), 64'd4);

      // pop twice from {A,B}
      do_reset();
      push1(32'hA, 0); push1(32'hB, 1);
      pop1();
      chk("pop1_dup", 64'(in_dup_mode), 64'd1);
      chk("pop1_head", 64'(head_instr), 64'hB);
      pop1();
      chk("pop2_empty", 64'(is_empty), 64'd1);
      chk("pop2_dup", 64'(in_dup_mode), 64'd0);
      pop1();
      chk("underflow_count", 64'(count), 64'd0);

      // simultaneous push/pop from {A}, across pointer wrap
      do_reset();
      push1(32'hA, 0);
      for (int i = 0; i < 6; i++) begin
         step(0, 1, 1, 1, 32'h100 + 32'(i), 1'(i), 0, 0, 0);
         chk("pp_count", 64'(count), 64'd1);
         chk("pp_head", 64'(head_instr), 64'h100 + 64'(i));
         chk("pp_orig", 64'(in_dup_mode), 64'd0);
      end

      // enable low holds state
      push1(32'h55, 1);
      step(0, 0, 1, 1, 32'h66, 0, 1, 0, 0);
      chk("hold_count", 64'(count), 64'd2);
      chk("hold_pass", 64'(in_passthru_mode), 64'd0);

      // passthru entry, frozen queue, explicit exit
      do_reset();
      push1(32'hA, 0); push1(32'hB, 0);
      step(0, 1, 0, 0, '0, 0, 1, 0, 0);
      chk("pt_enter", 64'(in_passthru_mode), 64'd1);
      step(0, 1, 1, 1, 32'hC, 0, 0, 0, 0);
      chk("pt_frozen", 64'(count), 64'd2);
      step(0, 1, 0, 0, '0, 0, 0, 1, 0);
      chk("pt_exit_orig", 64'(in_passthru_mode), 64'd0);
      chk("pt_exit_empty", 64'(is_empty), 64'd1);

      // flush beats goto while in DUP with count 3
      do_reset();
      push1(32'h1, 0); push1(32'h2, 0); push1(32'h3, 0); push1(32'h4, 0);
      pop1();
      chk("dup3_mode", 64'(in_dup_mode), 64'd1);
      chk("dup3_count", 64'(count), 64'd3);
      step(0, 1, 1, 0, 32'h9, 0, 1, 0, 1);
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_pass", 64'(in_passthru_mode), 64'd0);
      chk("flush_dup", 64'(in_dup_mode), 64'd0);

`ifdef FV_DUP_QUEUE_AUTO_EXIT_EN
      // auto-exit length with enable high, then with two enable-low cycles
      for (int k = 0; k < 2; k++) begin
         do_reset();
         step(0, 1, 0, 0, '0, 0, 1, 0, 0);
         pass_cycles = 0;
         for (int i = 0; i < 40 && in_passthru_mode; i++) begin
            pass_cycles++;
            step(0, !(k == 1 && (i == 2 || i == 5)), 0, 0, '0, 0, 0, 0, 0);
         end
         chk("auto_exit_len", 64'(pass_cycles), (k == 0) ? 64'd8 : 64'd10);
      end
`endif

      // randomized traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 99) == 0,
              $urandom_range(0, 9) < 8,
              $urandom_range(0, 1) == 1,
              $urandom_range(0, 9) < 4,
              W'($urandom),
              1'($urandom_range(0, 1)),
              $urandom_range(0, 19) == 0,
              $urandom_range(0, 5) == 0,
              $urandom_range(0, 29) == 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
